// File: rtl/reg_file_param.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : reg_file_param                                              |
// | Function : DEPTH x WIDTH register file, byte-masked write, two async   |
// |            reads, optional zero entry / bypass, sequential clear.      |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module reg_file_param #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 we,
   input  logic [ADDR_W-1:0]    waddr,
   input  logic [WIDTH-1:0]     wdata,
   input  logic [WIDTH/8-1:0]   wbe,
   input  logic [ADDR_W-1:0]    raddr_a,
   output logic [WIDTH-1:0]     rdata_a,
   input  logic [ADDR_W-1:0]    raddr_b,
   output logic [WIDTH-1:0]     rdata_b,
   input  logic                 clr_req,
   output logic                 clr_busy,
   output logic                 clr_done
);

   localparam int                NBYTES  = WIDTH / 8;
   localparam logic [ADDR_W:0]   C_DEPTH = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] C_LAST  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] C_ONE   = ADDR_W'(1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CLEAR = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [WIDTH-1:0]  r_mem [DEPTH];
   logic [1:0]        r_state;
   logic [1:0]        w_next;
   logic [ADDR_W-1:0] r_cnt;
   logic              w_wr_ok;
   logic [WIDTH-1:0]  w_old;
   logic [WIDTH-1:0]  w_merged;

   // An address is usable when it maps to a real, writable/readable entry.
   function automatic logic f_valid(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < C_DEPTH) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   assign w_wr_ok = we && (r_state != S_CLEAR) && f_valid(waddr) && (wbe != '0);

   always_comb begin
      w_old = '0;
      if ({1'b0, waddr} < C_DEPTH) w_old = r_mem[waddr];
   end

   for (genvar k = 0; k < NBYTES; k++) begin : g_byte
      assign w_merged[8*k +: 8] = wbe[k] ? wdata[8*k +: 8] : w_old[8*k +: 8];
   end

   always_comb begin
      rdata_a = '0;
      if (f_valid(raddr_a)) begin
         if ((BYPASS != 0) && w_wr_ok && (raddr_a == waddr)) rdata_a = w_merged;
         else                                                rdata_a = r_mem[raddr_a];
      end
   end

   always_comb begin
      rdata_b = '0;
      if (f_valid(raddr_b)) begin
         if ((BYPASS != 0) && w_wr_ok && (raddr_b == waddr)) rdata_b = w_merged;
         else                                                rdata_b = r_mem[raddr_b];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (clr_req) w_next = S_CLEAR;
         S_CLEAR: if (r_cnt == C_LAST) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      clr_busy = (r_state == S_CLEAR);
      clr_done = (r_state == S_DONE);
   end

   // Counter parks at 0 outside CLEAR so every clear starts at entry 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (r_state == S_CLEAR) begin
         r_mem[r_cnt] <= '0;
         r_cnt        <= r_cnt + C_ONE;
      end else begin
         r_cnt <= '0;
         if (w_wr_ok) r_mem[waddr] <= w_merged;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_param.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_reg_file_param                                           |
// | Function : self-checking bench, two configurations against a model.    |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_reg_file_param;
   localparam int AW = 6;

   logic          clk = 1'b0, rst_n = 1'b0, we = 1'b0, clr_req = 1'b0;
   logic [AW-1:0] waddr = '0, raddr_a = '0, raddr_b = '0;
   logic [31:0]   wdata = '0;
   logic [3:0]    wbe = '0;
   logic [31:0]   rda0, rdb0, rda1, rdb1;
   logic          busy0, done0, busy1, done1;
   logic          checking = 1'b0;
   int            checks = 0, errors = 0;

   // Instance 0: 32 entries, zero entry, no bypass. Instance 1: 20 entries, bypass.
   reg_file_param #(.WIDTH(32), .DEPTH(32), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0)) u_a (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
      .raddr_a(raddr_a), .rdata_a(rda0), .raddr_b(raddr_b), .rdata_b(rdb0),
      .clr_req(clr_req), .clr_busy(busy0), .clr_done(done0));
   reg_file_param #(.WIDTH(32), .DEPTH(20), .ADDR_W(AW), .ZERO_REG(0), .BYPASS(1)) u_b (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
      .raddr_a(raddr_a), .rdata_a(rda1), .raddr_b(raddr_b), .rdata_b(rdb1),
      .clr_req(clr_req), .clr_busy(busy1), .clr_done(done1));

   always #5 clk = ~clk;

   // pos: -1 idle, 0..D-1 index being cleared, D the done cycle.
   logic [31:0] mem [2][32];
   int          pos [2];

   function automatic int dep(input int i);  return (i == 0) ? 32 : 20; endfunction
   function automatic bit zr(input int i);   return i == 0;              endfunction
   function automatic bit byp(input int i);  return i == 1;              endfunction
   function automatic bit clearing(input int i); return pos[i] >= 0 && pos[i] < dep(i); endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] be);
      logic [31:0] r = o;
      for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = d[8*k +: 8];
      return r;
   endfunction

   function automatic bit wvalid(input int i);
      return we && !clearing(i) && int'(waddr) < dep(i) && !(zr(i) && waddr == '0)
             && wbe != 4'h0;
   endfunction

   function automatic logic [31:0] exp_rd(input int i, input logic [AW-1:0] a);
      if (int'(a) >= dep(i) || (zr(i) && a == '0)) return 32'h0;
      if (byp(i) && wvalid(i) && a == waddr) return merge(mem[i][int'(waddr)], wdata, wbe);
      return mem[i][int'(a)];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            for (int j = 0; j < 32; j++) mem[i][j] = 32'h0;
            pos[i] = -1;
         end else if (clearing(i)) begin
            mem[i][pos[i]] = 32'h0;
            pos[i]++;
         end else begin
            if (wvalid(i)) mem[i][int'(waddr)] = merge(mem[i][int'(waddr)], wdata, wbe);
            if (pos[i] == dep(i)) pos[i] = -1;
            else if (clr_req)     pos[i] = 0;
         end
      end
   endtask

   // Inputs only change just after a rising edge, so at the falling edge they are the
   // values the next edge will sample.
   initial begin
      for (int i = 0; i < 2; i++) begin
         pos[i] = -1;
         for (int j = 0; j < 32; j++) mem[i][j] = 32'h0;
      end
      forever begin
         @(negedge clk);
         if (checking) begin
            chk("A.rdata_a", rda0, exp_rd(0, raddr_a));
            chk("A.rdata_b", rdb0, exp_rd(0, raddr_b));
            chk("A.clr_busy", 32'(busy0), 32'(clearing(0)));
            chk("A.clr_done", 32'(done0), 32'(pos[0] == dep(0)));
            chk("B.rdata_a", rda1, exp_rd(1, raddr_a));
            chk("B.rdata_b", rdb1, exp_rd(1, raddr_b));
            chk("B.clr_busy", 32'(busy1), 32'(clearing(1)));
            chk("B.clr_done", 32'(done1), 32'(pos[1] == dep(1)));
         end
         model_step();
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
      waddr = a; wdata = d; wbe = be; we = 1'b1;
      tick();
      we = 1'b0;
   endtask

   initial begin
      int nb0, nb1, d0, d1, dc0, dc1;
      tick();
      rst_n = 1'b1;
      checking = 1'b1;

      for (int i = 0; i < 40; i++) begin
         raddr_a = AW'(i); raddr_b = AW'(39 - i);
         @(negedge clk);
         chk("rst_A_rda", rda0, 32'h0);
         chk("rst_B_rdb", rdb1, 32'h0);
         chk("rst_A_busy", 32'(busy0 | done0), 32'h0);
         tick();
      end

      wr(5, 32'hDEADBEEF, 4'hF);
      raddr_a = 5;
      @(negedge clk);
      chk("wr_full_A", rda0, 32'hDEADBEEF);
      chk("wr_full_B", rda1, 32'hDEADBEEF);
      tick();
      wr(5, 32'h11223344, 4'b0101);
      @(negedge clk);
      chk("wr_mask_A", rda0, 32'hDE22BE44);
      tick();

      wr(0, 32'hFFFFFFFF, 4'hF);
      raddr_b = 0;
      @(negedge clk);
      chk("zero_A", rdb0, 32'h0);
      chk("nozero_B", rdb1, 32'hFFFFFFFF);
      tick();
      wr(40, 32'h77777777, 4'hF);
      wr(5, 32'h0, 4'h0);
      wr(25, 32'h55555555, 4'hF);
      raddr_a = 40; raddr_b = 5;
      @(negedge clk);
      chk("oor_A40", rda0, 32'h0);
      chk("wbe0_A5", rdb0, 32'hDE22BE44);
      chk("wbe0_B5", rdb1, 32'hDE22BE44);
      tick();
      raddr_a = 25;
      @(negedge clk);
      chk("inr_A25", rda0, 32'h55555555);
      chk("oor_B25", rda1, 32'h0);
      tick();

      wr(7, 32'h12345678, 4'hF);
      waddr = 7; wdata = 32'hA5A5A5A5; wbe = 4'hF; we = 1'b1; raddr_a = 7;
      @(negedge clk);
      chk("nobyp_A", rda0, 32'h12345678);
      chk("byp_B", rda1, 32'hA5A5A5A5);
      tick();
      we = 1'b0;
      @(negedge clk);
      chk("after_byp_A", rda0, 32'hA5A5A5A5);
      tick();
      waddr = 7; wdata = 32'h0; wbe = 4'b0011; we = 1'b1; raddr_b = 7;
      @(negedge clk);
      chk("byp_mask_B", rdb1, 32'hA5A50000);
      chk("nobyp_mask_A", rdb0, 32'hA5A5A5A5);
      tick();
      we = 1'b0;

      for (int i = 0; i < 32; i++) wr(AW'(i), 32'h01010101 * (i + 1), 4'hF);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      waddr = 3; wdata = 32'hFFFFFFFF; wbe = 4'hF; we = 1'b1;
      nb0 = 0; nb1 = 0; d0 = 0; d1 = 0; dc0 = 0; dc1 = 0;
      for (int n = 1; n <= 40; n++) begin
         clr_req = (n == 5);
         if (n == 19) we = 1'b0;
         @(negedge clk);
         if (busy0) nb0++;
         if (busy1) nb1++;
         if (done0) begin d0 = n; dc0++; end
         if (done1) begin d1 = n; dc1++; end
         tick();
      end
      clr_req = 1'b0;
      chk("clr_busy_len_A", 32'(nb0), 32'd32);
      chk("clr_done_at_A", 32'(d0), 32'd33);
      chk("clr_done_cnt_A", 32'(dc0), 32'd1);
      chk("clr_busy_len_B", 32'(nb1), 32'd20);
      chk("clr_done_at_B", 32'(d1), 32'd21);
      for (int i = 0; i < 32; i++) begin
         raddr_a = AW'(i); raddr_b = AW'(i);
         @(negedge clk);
         chk("cleared_A", rda0, 32'h0);
         chk("cleared_B", rdb1, 32'h0);
         tick();
      end

      waddr = 9; wdata = 32'hCAFEF00D; wbe = 4'hF; we = 1'b1; clr_req = 1'b1;
      tick();
      we = 1'b0; raddr_a = 9;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (n == 1)  chk("wr_then_clr_A", rda0, 32'hCAFEF00D);
         if (n == 33) chk("held_done_A", 32'(done0), 32'd1);
         if (n == 35) chk("held_restart_A", 32'(busy0), 32'd1);
         tick();
      end
      clr_req = 1'b0;
      for (int n = 0; n < 70; n++) tick();

      wr(2, 32'h22222222, 4'hF);
      wr(30, 32'h30303030, 4'hF);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      for (int n = 0; n < 9; n++) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      nb0 = 0; dc0 = 0; nb1 = 0; dc1 = 0;
      for (int i = 0; i < 40; i++) begin
         raddr_a = AW'(i); raddr_b = AW'(i);
         @(negedge clk);
         if (busy0) nb0++;
         if (done0) dc0++;
         if (busy1) nb1++;
         if (done1) dc1++;
         chk("rst_mid_A", rda0, 32'h0);
         chk("rst_mid_B", rdb1, 32'h0);
         tick();
      end
      chk("rst_mid_busy_A", 32'(nb0 + nb1), 32'd0);
      chk("rst_mid_done", 32'(dc0 + dc1), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
